key_watchdog: RTL and testbench
===============================

# key_watchdog

Parametrised licence watchdog: compares a serially delivered key against the device identifier and, unless a correct key arrives within a programmable timeout, issues a fixed-width reset pulse to the rest of the FPGA. It adds mismatch detection, a saturating failure counter and a permanent lockout after repeated failures. It sits beside the DNA reader. Its reset output drives the design's global reset tree.

## Interface
- KEY_BITS, 57: identifier/key width compared.
- TIMEOUT_CYCLES, 50000000: cycles without a good key before expiry (≥2).
- RESET_PULSE_CYCLES, 16: width of each reset_out pulse (≥1).
- MAX_FAILS, 3: failures (expiries + mismatches) that trigger lockout (1..255).

- clk  in  1  system clock; everything is synchronous to it.
- rst  in  1  synchronous, active-high reset.
- id  in  KEY_BITS  device identifier to match.
- id_valid  in  1  id is stable; compares are suppressed while low.
- key_start  in  1  begins a frame: clears bit count and shift register.
- key_en  in  1  qualifies key_bit; one bit shifted per cycle, MSB first.
- key_bit  in  1  serial key data.
- key_ok  out  1  one-cycle pulse, good frame accepted.
- key_bad  out  1  one-cycle pulse, mismatched or over-length frame.
- reset_out  out  1  reset to design; pulsed on failure, held in lockout.
- locked  out  1  lockout state.
- fail_count  out  8  failures since last good key, saturating at MAX_FAILS.

## Operation
- States: RUN, PULSE, LOCK. After rst: RUN, timer=0, fail_count=0, all outputs 0.
- Frame: key_start zeroes bit_cnt. Each key_en cycle shifts key_bit in and increments bit_cnt. When bit_cnt reaches KEY_BITS, the frame is complete. Compare happens the next cycle. Frames without a preceding key_start are legal; bit_cnt always starts at 0 after rst.
- A key_en that arrives after the frame is complete and before key_start marks the frame over-length. The result is key_bad once, with no further compare.
- If key_start and key_en occur in the same cycle, key_start clears and the bit is shifted in as bit 0.
- Compare (RUN, id_valid=1): on match, key_ok fires, timer is set to 0 and fail_count to 0. On mismatch, key_bad fires and a failure event is raised.
- Compare with id_valid=0: the frame is discarded silently.
- Timer: increments in RUN. At TIMEOUT_CYCLES-1 it raises a failure event and is set to 0.
- Failure event: fail_count increments, saturating. If the new value is MAX_FAILS, go to LOCK; otherwise go to PULSE.
- PULSE: reset_out=1 for exactly RESET_PULSE_CYCLES cycles, then RUN. The timer is held at 0 throughout. Frames completing in PULSE are discarded, with no key_ok and no key_bad.
- LOCK: reset_out=1 and locked=1 until rst. Keys are ignored.
- Simultaneous good compare and timer expiry in the same cycle: the good key wins, with no failure.
- Mismatch and expiry in the same cycle: one failure, counted once.

## Timing
- key_ok/key_bad are asserted on the cycle after the final key_en cycle.
- reset_out rises on the cycle after the failure event is registered. With no keys after rst, reset_out first rises TIMEOUT_CYCLES+1 cycles after rst deasserts.
- reset_out falls RESET_PULSE_CYCLES cycles later. The timer restarts from 0 on the first RUN cycle.
- rst mid-PULSE or in LOCK: everything returns to reset values on the next edge.
- All outputs are registered.

## Structure
- Shared package `key_watchdog_pkg`: state enumeration (RUN/PULSE/LOCK) and the `binary_width` sizing function used for timer, pulse-counter and bit_cnt widths.
- Sub-module `key_shift`: KEY_BITS shift register plus bit counter, with frame-complete and over-length flags. The parent holds the FSM, timer, pulse counter and fail counter.

## Test plan
Default bench parameters: KEY_BITS=8, TIMEOUT_CYCLES=100, RESET_PULSE_CYCLES=4, MAX_FAILS=3, id=8'hA5, id_valid=1.

1. Shift 8'hA5 every 60 cycles -> key_ok each time, reset_out never asserted, fail_count=0.
2. No keys after rst -> reset_out high on cycles 101–104, fail_count=1. Next pulse at cycles 205–208, fail_count=2. On the third expiry: locked=1 and reset_out stuck high.
3. Shift 8'h5A -> key_bad and a 4-cycle pulse; fail_count=1. Then shift 8'hA5 -> key_ok and fail_count=0.
4. Shift 9 bits without key_start -> key_bad once (over-length); then key_start followed by 8'hA5 -> key_ok.
5. Good frame completes on the same cycle the timer reaches 99 -> key_ok, no pulse, fail_count unchanged. Separately, a frame completing during PULSE -> no key_ok and no key_bad.
6. Assert rst during LOCK and again mid-PULSE -> reset_out=0, locked=0, fail_count=0 on the following cycle.

Source files
------------

// File: rtl/key_watchdog_pkg.sv
// Shared types and sizing helpers for the key watchdog and its key shifter.
package key_watchdog_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_PULSE = 2'd1,
        ST_LOCK  = 2'd2
    } wd_state_t;

    localparam int FAIL_W = 8;

    // Number of bits needed to hold 'value' (at least 1).
    function automatic int binary_width(input int unsigned value);
        int w;
        w = 1;
        while ((value >> w) != 0) begin
            w++;
        end
        return w;
    endfunction

endpackage

// File: rtl/key_watchdog_shift.sv
// Serial key collector: MSB-first shift register with bit counter, reporting
// the cycle a frame completes and the first bit that overruns a full frame.
module key_shift
    import key_watchdog_pkg::*;
#(
    parameter int KEY_BITS = 57
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_start_i,
    input  logic                key_en_i,
    input  logic                key_bit_i,
    output logic                frame_done_o,
    output logic                over_len_o,
    output logic [KEY_BITS-1:0] frame_word_o
);

    localparam int CW = binary_width(KEY_BITS);

    logic [KEY_BITS-1:0] shift_q, shift_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                ovf_q, ovf_d;

    // frame_done_o and frame_word_o look one step ahead so the parent can
    // register the compare result on the same edge that takes the last bit.
    always_comb begin
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        ovf_d        = ovf_q;
        frame_done_o = 1'b0;
        over_len_o   = 1'b0;
        if (key_start_i) begin
            shift_d = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
        end
        if (key_en_i) begin
            if (cnt_d == CW'(KEY_BITS)) begin
                over_len_o = ~ovf_d;
                ovf_d      = 1'b1;
            end else begin
                shift_d      = {shift_d[KEY_BITS-2:0], key_bit_i};
                cnt_d        = cnt_d + CW'(1);
                frame_done_o = (cnt_d == CW'(KEY_BITS));
            end
        end
        frame_word_o = shift_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_q <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: rtl/key_watchdog.sv
// Licence watchdog: accepts a serial key, pulses reset_out on timeout or bad
// key, and locks the design in reset after MAX_FAILS failures.
module key_watchdog
    import key_watchdog_pkg::*;
#(
    parameter int KEY_BITS           = 57,
    parameter int TIMEOUT_CYCLES     = 50000000,
    parameter int RESET_PULSE_CYCLES = 16,
    parameter int MAX_FAILS          = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [KEY_BITS-1:0] id,
    input  logic                id_valid,
    input  logic                key_start,
    input  logic                key_en,
    input  logic                key_bit,
    output logic                key_ok,
    output logic                key_bad,
    output logic                reset_out,
    output logic                locked,
    output logic [FAIL_W-1:0]   fail_count
);

    localparam int TW = binary_width(TIMEOUT_CYCLES - 1);
    localparam int PW = binary_width(RESET_PULSE_CYCLES - 1);

    wd_state_t           state_q;
    logic [TW-1:0]       timer_q;
    logic [PW-1:0]       pulse_q;
    logic [FAIL_W-1:0]   fail_q, fail_d;
    logic                key_ok_q, key_bad_q, reset_out_q, locked_q;

    logic                frame_done, over_len;
    logic [KEY_BITS-1:0] frame_word;
    logic                good_key, bad_key, expire;

    key_shift #(
        .KEY_BITS(KEY_BITS)
    ) u_shift (
        .clk         (clk),
        .rst         (rst),
        .key_start_i (key_start),
        .key_en_i    (key_en),
        .key_bit_i   (key_bit),
        .frame_done_o(frame_done),
        .over_len_o  (over_len),
        .frame_word_o(frame_word)
    );

    always_comb begin
        good_key = frame_done & id_valid & (frame_word == id);
        bad_key  = frame_done & id_valid & (frame_word != id);
        expire   = (timer_q == TW'(TIMEOUT_CYCLES - 1));
        fail_d   = (fail_q >= FAIL_W'(MAX_FAILS)) ? fail_q : fail_q + FAIL_W'(1);
    end

    // An over-length frame is reported as key_bad but is not a failure event.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            timer_q     <= '0;
            pulse_q     <= '0;
            fail_q      <= '0;
            key_ok_q    <= 1'b0;
            key_bad_q   <= 1'b0;
            reset_out_q <= 1'b0;
            locked_q    <= 1'b0;
        end else begin
            key_ok_q    <= 1'b0;
            key_bad_q   <= 1'b0;
            reset_out_q <= (state_q != ST_RUN);
            locked_q    <= (state_q == ST_LOCK);
            case (state_q)
                ST_RUN: begin
                    if (good_key) begin
                        key_ok_q <= 1'b1;
                        timer_q  <= '0;
                        fail_q   <= '0;
                    end else begin
                        key_bad_q <= bad_key | over_len;
                        if (bad_key | expire) begin
                            fail_q  <= fail_d;
                            timer_q <= '0;
                            pulse_q <= '0;
                            state_q <= (fail_d == FAIL_W'(MAX_FAILS)) ? ST_LOCK : ST_PULSE;
                        end else begin
                            timer_q <= timer_q + TW'(1);
                        end
                    end
                end
                ST_PULSE: begin
                    timer_q <= '0;
                    if (pulse_q == PW'(RESET_PULSE_CYCLES - 1)) begin
                        state_q <= ST_RUN;
                    end else begin
                        pulse_q <= pulse_q + PW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign key_ok     = key_ok_q;
    assign key_bad    = key_bad_q;
    assign reset_out  = reset_out_q;
    assign locked     = locked_q;
    assign fail_count = fail_q;

endmodule

// File: tb/tb_key_watchdog.sv
// Directed and randomized bench for key_watchdog with a queue-based reference model.
module tb_key_watchdog;

    localparam int KB = 8;
    localparam int TO = 100;
    localparam int PL = 4;
    localparam int MF = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [KB-1:0] id = 8'hA5;
    logic          id_valid = 1'b1;
    logic          key_start = 1'b0;
    logic          key_en = 1'b0;
    logic          key_bit = 1'b0;
    logic          key_ok, key_bad, reset_out, locked;
    logic [7:0]    fail_count;

    key_watchdog #(
        .KEY_BITS(KB), .TIMEOUT_CYCLES(TO), .RESET_PULSE_CYCLES(PL), .MAX_FAILS(MF)
    ) dut (
        .clk(clk), .rst(rst), .id(id), .id_valid(id_valid),
        .key_start(key_start), .key_en(key_en), .key_bit(key_bit),
        .key_ok(key_ok), .key_bad(key_bad), .reset_out(reset_out),
        .locked(locked), .fail_count(fail_count)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ok_cnt, bad_cnt, rhi_cnt;
    int rises[$];
    int falls[$];
    logic prev_rout = 1'b0;

    // Reference model: frame as a queue of bits, pulse as remaining-cycle count.
    bit m_bits[$];
    bit m_over;
    int m_timer, m_fails, m_pulse_left;
    bit m_locked;
    bit e_ok, e_bad, e_rst, e_lock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_step(input logic r, input logic ks, input logic ke, input logic kb, input logic iv);
        bit done, ovl, good, mism, expire;
        int word;
        if (r) begin
            m_bits.delete();
            m_over = 0; m_timer = 0; m_fails = 0; m_pulse_left = 0; m_locked = 0;
            e_ok = 0; e_bad = 0; e_rst = 0; e_lock = 0;
            return;
        end
        e_rst  = (m_pulse_left > 0) || m_locked;
        e_lock = m_locked;
        e_ok   = 0;
        e_bad  = 0;
        done   = 0;
        ovl    = 0;
        if (ks) begin
            m_bits.delete();
            m_over = 0;
        end
        if (ke) begin
            if (m_bits.size() == KB) begin
                ovl    = !m_over;
                m_over = 1;
            end else begin
                m_bits.push_back(kb);
                done = (m_bits.size() == KB);
            end
        end
        word = 0;
        foreach (m_bits[i]) word = word * 2 + int'(m_bits[i]);
        if (m_locked) begin
        end else if (m_pulse_left > 0) begin
            m_pulse_left--;
            m_timer = 0;
        end else begin
            good   = done && iv && (word == int'(id));
            mism   = done && iv && (word != int'(id));
            expire = (m_timer == TO - 1);
            if (good) begin
                e_ok = 1; m_timer = 0; m_fails = 0;
            end else begin
                e_bad = mism || ovl;
                if (mism || expire) begin
                    m_fails = (m_fails + 1 > MF) ? MF : m_fails + 1;
                    m_timer = 0;
                    if (m_fails == MF) m_locked = 1;
                    else m_pulse_left = PL;
                end else begin
                    m_timer++;
                end
            end
        end
    endtask

    task automatic step(input logic r, input logic ks, input logic ke, input logic kb, input logic iv);
        rst = r; key_start = ks; key_en = ke; key_bit = kb; id_valid = iv;
        @(posedge clk);
        model_step(r, ks, ke, kb, iv);
        #1;
        cyc++;
        check("key_ok", key_ok, e_ok);
        check("key_bad", key_bad, e_bad);
        check("reset_out", reset_out, e_rst);
        check("locked", locked, e_lock);
        check("fail_count", fail_count, m_fails);
        ok_cnt  += int'(key_ok);
        bad_cnt += int'(key_bad);
        rhi_cnt += int'(reset_out);
        if (reset_out && !prev_rout) rises.push_back(cyc);
        if (!reset_out && prev_rout) falls.push_back(cyc);
        prev_rout = reset_out;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1);
    endtask

    task automatic send_frame(input logic [KB-1:0] w, input bit with_start, input logic iv);
        for (int i = 0; i < KB; i++) step(0, with_start && (i == 0), 1, w[KB-1-i], iv);
    endtask

    task automatic do_reset();
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 1);
        cyc = 0; ok_cnt = 0; bad_cnt = 0; rhi_cnt = 0;
        rises.delete(); falls.delete();
    endtask

    initial begin
        // 1: good key every 60 cycles
        do_reset();
        check("rst_key_ok", key_ok, 0);
        check("rst_reset_out", reset_out, 0);
        check("rst_locked", locked, 0);
        check("rst_fail", fail_count, 0);
        for (int k = 0; k < 3; k++) begin
            idle(52);
            send_frame(8'hA5, 1, 1);
            check("p1_ok", key_ok, 1);
        end
        check("p1_no_pulse", rhi_cnt, 0);
        check("p1_ok_cnt", ok_cnt, 3);

        // 2: no keys -> pulses then lockout
        do_reset();
        idle(350);
        check("p2_rises", rises.size(), 3);
        check("p2_rise0", rises.size() > 0 ? rises[0] : -1, 101);
        check("p2_fall0", falls.size() > 0 ? falls[0] : -1, 105);
        check("p2_rise1", rises.size() > 1 ? rises[1] : -1, 205);
        check("p2_fall1", falls.size() > 1 ? falls[1] : -1, 209);
        check("p2_locked", locked, 1);
        check("p2_reset_out", reset_out, 1);
        check("p2_fail", fail_count, 3);

        // 3: bad key then good key
        do_reset();
        send_frame(8'h5A, 1, 1);
        check("p3_bad", key_bad, 1);
        check("p3_fail1", fail_count, 1);
        idle(7);
        check("p3_pulse_width", rhi_cnt, PL);
        send_frame(8'hA5, 1, 1);
        check("p3_ok", key_ok, 1);
        check("p3_fail0", fail_count, 0);

        // 4: over-length frame
        do_reset();
        send_frame(8'hA5, 0, 1);
        check("p4_ok", key_ok, 1);
        step(0, 0, 1, 1'($urandom_range(0, 1)), 1);
        check("p4_overlen", key_bad, 1);
        step(0, 0, 1, 1'($urandom_range(0, 1)), 1);
        idle(10);
        check("p4_bad_once", bad_cnt, 1);
        send_frame(8'hA5, 1, 1);
        check("p4_ok2", key_ok, 1);

        // 5a: good key completes as timer reaches TO-1
        do_reset();
        idle(92);
        send_frame(8'hA5, 1, 1);
        check("p5_ok", key_ok, 1);
        idle(6);
        check("p5_no_pulse", rhi_cnt, 0);
        check("p5_fail", fail_count, 0);

        // 5b: frame completes inside the pulse
        do_reset();
        idle(96);
        send_frame(8'hA5, 1, 1);
        idle(6);
        check("p5b_no_ok", ok_cnt, 0);
        check("p5b_no_bad", bad_cnt, 0);
        check("p5b_fail", fail_count, 1);
        check("p5b_pulse", rhi_cnt, PL);

        // 6: reset during lock and mid-pulse
        do_reset();
        idle(330);
        check("p6_locked", locked, 1);
        step(1, 0, 0, 0, 1);
        check("p6_rst_rout", reset_out, 0);
        check("p6_rst_lock", locked, 0);
        check("p6_rst_fail", fail_count, 0);
        cyc = 0;
        idle(102);
        check("p6_mid_pulse", reset_out, 1);
        step(1, 0, 0, 0, 1);
        check("p6_rst2_rout", reset_out, 0);
        check("p6_rst2_fail", fail_count, 0);

        // 7: randomized segments against the model
        do_reset();
        for (int seg = 0; seg < 150; seg++) begin
            automatic int kind = $urandom_range(0, 5);
            automatic logic iv = ($urandom_range(0, 9) != 0);
            case (kind)
                0: for (int i = 0; i < $urandom_range(1, 40); i++) step(0, 0, 0, 0, iv);
                1: send_frame(8'hA5, 1, iv);
                2: send_frame(8'($urandom), 1'($urandom_range(0, 1)), iv);
                3: for (int i = 0; i < $urandom_range(1, 20); i++)
                       step(0, $urandom_range(0, 7) == 0, 1'($urandom_range(0, 1)),
                            1'($urandom_range(0, 1)), iv);
                4: if ($urandom_range(0, 3) == 0) step(1, 0, 0, 0, 1);
                   else step(0, 0, 0, 0, iv);
                default: send_frame(8'hA5, 0, iv);
            endcase
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
